cd_rx_ram: RTL and testbench

// - Multi-page receive frame buffer between the bus receiver (writer) and the host register interface (reader).
// - Receiver writes one frame into the current write page, then pulses switch to commit it.
// - Host reads committed pages in arrival order and releases each with rd_done.
// - Pages form a ring; a commit is dropped, and lost pulses, when no free page remains.

---
 rtl/cd_rx_ram.sv | 217 +++++++++++++++++++++
 tb/tb_cd_rx_ram.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cd_rx_ram.sv
// ---------------------------------------------------------------------------
// cd_rx_ram: multi-page receive frame buffer.
//
// The bus receiver writes one frame into the current write page and pulses
// switch to commit it. The host reads committed pages in arrival order and
// releases each one with rd_done. The pages form a ring. If no free page
// remains, a commit is dropped and lost pulses for one cycle.
//
// Optional feature macro: CD_RX_RAM_LEN_EN
//   When defined, each committed page also records its byte length. The
//   length is the highest written address + 1, and it is presented on
//   rd_len for the current read page.
//
// Parameters
//   PAGE_NUM  number of 256x8 pages; must be a power of two, 2..16
//
// Ports
//   clk       in   1  clock
//   reset_n   in   1  asynchronous reset, active low
//   rd_byte   out  8  read data from the current read page (1 cycle after rd_en)
//   rd_addr   in   8  read byte address
//   rd_en     in   1  read strobe
//   rd_done   in   1  pulse: release the current read page
//   unread    out  1  at least one committed page is waiting
//   wr_byte   in   8  write data
//   wr_addr   in   8  write byte address
//   wr_en     in   1  write strobe into the current write page
//   switch    in   1  pulse: commit the current write page
//   rd_len    out  9  [CD_RX_RAM_LEN_EN] byte length of the current read page
//   lost      out  1  pulse: a commit was dropped because the buffer was full
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// cd_spram: 256x8 single-port RAM.
//   cen_i and wen_i are active low. A read is registered, so dout_o is valid
//   one cycle after the read. The RAM has no reset.
// ---------------------------------------------------------------------------
module cd_spram (
  input  logic       clk,
  input  logic       cen_i,
  input  logic       wen_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o
);

  logic [7:0] mem_q [256];

  always_ff @(posedge clk) begin
    if (!cen_i) begin
      if (!wen_i) begin
        mem_q[addr_i] <= din_i;
      end else begin
        dout_o <= mem_q[addr_i];
      end
    end
  end

endmodule

module cd_rx_ram #(
  parameter int PAGE_NUM = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] rd_byte,
  input  logic [7:0] rd_addr,
  input  logic       rd_en,
  input  logic       rd_done,
  output logic       unread,
  input  logic [7:0] wr_byte,
  input  logic [7:0] wr_addr,
  input  logic       wr_en,
  input  logic       switch,
`ifdef CD_RX_RAM_LEN_EN
  output logic [8:0] rd_len,
`endif
  output logic       lost
);

  localparam int PTR_W = $clog2(PAGE_NUM);
  localparam logic [PTR_W-1:0] CNT_FULL = PTR_W'(PAGE_NUM - 1);

  logic [PTR_W-1:0] wr_sel_q, wr_sel_d;
  logic [PTR_W-1:0] rd_sel_q, rd_sel_d;
  logic [PTR_W-1:0] cnt_q, cnt_d;
  // Page that produced the last read, so read data stays valid after
  // rd_done moves rd_sel on.
  logic [PTR_W-1:0] rd_sel_dl_q, rd_sel_dl_d;
  logic             lost_q, lost_d;

  logic             full;
  logic             commit;
  logic             release_pg;

  logic [7:0]       page_rdata [PAGE_NUM];

  // -------------------------------------------------------------------------
  // Page storage
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < PAGE_NUM; i++) begin : g_page
    logic       pg_we;
    logic       pg_re;
    logic [7:0] pg_addr;

    assign pg_we = wr_en & (wr_sel_q == PTR_W'(i));
    assign pg_re = rd_en & (rd_sel_q == PTR_W'(i));
    // The write wins a same-page collision. That can only happen when
    // the ring is empty, so the read data is meaningless anyway.
    assign pg_addr = pg_we ? wr_addr : rd_addr;

    cd_spram u_ram (
      .clk    (clk),
      .cen_i  (~(pg_we | pg_re)),
      .wen_i  (~pg_we),
      .addr_i (pg_addr),
      .din_i  (wr_byte),
      .dout_o (page_rdata[i])
    );
  end

  assign rd_byte = page_rdata[rd_sel_dl_q];

  // -------------------------------------------------------------------------
  // Ring control
  // -------------------------------------------------------------------------
  // The full check uses the pre-cycle count. A switch at CNT_FULL is
  // therefore dropped even if rd_done frees a page in the same cycle.
  assign full       = (cnt_q == CNT_FULL);
  assign commit     = switch & ~full;
  assign release_pg = rd_done & (cnt_q != '0);

  always_comb begin
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    cnt_d       = cnt_q;
    rd_sel_dl_d = rd_sel_dl_q;
    lost_d      = switch & full;

    // The pointers are PTR_W bits wide and PAGE_NUM is a power of two,
    // so an increment wraps around the ring on its own.
    if (commit) begin
      wr_sel_d = wr_sel_q + 1'b1;
    end
    if (release_pg) begin
      rd_sel_d = rd_sel_q + 1'b1;
    end

    unique case ({commit, release_pg})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (rd_en) begin
      rd_sel_dl_d = rd_sel_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_sel_q    <= '0;
      rd_sel_q    <= '0;
      cnt_q       <= '0;
      rd_sel_dl_q <= '0;
      lost_q      <= 1'b0;
    end else begin
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      cnt_q       <= cnt_d;
      rd_sel_dl_q <= rd_sel_dl_d;
      lost_q      <= lost_d;
    end
  end

  assign unread = (cnt_q != '0);
  assign lost   = lost_q;

`ifdef CD_RX_RAM_LEN_EN
  // -------------------------------------------------------------------------
  // Frame length tracking
  // -------------------------------------------------------------------------
  logic [8:0] hw_len_q, hw_len_d;
  // Running length including this cycle's write. This lets a write in the
  // switch cycle count toward the committed length.
  logic [8:0] hw_len_upd;
  logic [8:0] wr_len;
  logic [8:0] len_q [PAGE_NUM];

  always_comb begin
    wr_len     = {1'b0, wr_addr} + 9'd1;
    hw_len_upd = hw_len_q;
    if (wr_en && (wr_len > hw_len_q)) begin
      hw_len_upd = wr_len;
    end
    // A dropped frame also starts the next frame from zero.
    hw_len_d = switch ? 9'd0 : hw_len_upd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hw_len_q <= 9'd0;
      for (int i = 0; i < PAGE_NUM; i++) begin
        len_q[i] <= 9'd0;
      end
    end else begin
      hw_len_q <= hw_len_d;
      if (commit) begin
        len_q[wr_sel_q] <= hw_len_upd;
      end
    end
  end

  assign rd_len = len_q[rd_sel_q];
`endif

endmodule

// File: tb/tb_cd_rx_ram.sv
module tb_cd_rx_ram;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rd_byte;
  logic [7:0] rd_addr = '0;
  logic       rd_en = 1'b0;
  logic       rd_done = 1'b0;
  logic       unread;
  logic [7:0] wr_byte = '0;
  logic [7:0] wr_addr = '0;
  logic       wr_en = 1'b0;
  logic       switch = 1'b0;
  logic       lost;
`ifdef CD_RX_RAM_LEN_EN
  logic [8:0] rd_len;
`endif

  int total = 0;
  int bad   = 0;

  cd_rx_ram #(.PAGE_NUM(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_byte (rd_byte),
    .rd_addr (rd_addr),
    .rd_en   (rd_en),
    .rd_done (rd_done),
    .unread  (unread),
    .wr_byte (wr_byte),
    .wr_addr (wr_addr),
    .wr_en   (wr_en),
    .switch  (switch),
`ifdef CD_RX_RAM_LEN_EN
    .rd_len  (rd_len),
`endif
    .lost    (lost)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle with any combination of write, switch and rd_done.
  task automatic step(input logic we, input logic [7:0] wa, input logic [7:0] wd,
                      input logic sw, input logic dn);
    wr_en   = we;
    wr_addr = wa;
    wr_byte = wd;
    switch  = sw;
    rd_done = dn;
    tick();
    wr_en   = 1'b0;
    switch  = 1'b0;
    rd_done = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    step(1'b1, a, d, 1'b0, 1'b0);
  endtask

  task automatic sw();
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic done();
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
    d       = rd_byte;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  logic [7:0] b;

  initial begin
    // Reset state
    #2;
    chk("reset_unread", unread, 0);
    chk("reset_lost", lost, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Basic write, commit, read
    wr(8'd0, 8'h11);
    wr(8'd1, 8'h22);
    wr(8'd2, 8'h33);
    chk("basic_unread_before", unread, 0);
    sw();
    chk("basic_unread", unread, 1);
    chk("basic_lost", lost, 0);
    rd(8'd1, b); chk("basic_rd1", b, 8'h22);
    rd(8'd0, b); chk("basic_rd0", b, 8'h11);
    rd(8'd2, b); chk("basic_rd2", b, 8'h33);
    done();
    chk("basic_unread_after", unread, 0);

    // Full ring: seven commits fit, the eighth is dropped
    for (int k = 0; k < 7; k++) begin
      wr(8'd0, 8'h50 + 8'(k));
      sw();
      chk("full_fill_lost", lost, 0);
    end
    chk("full_unread", unread, 1);
    wr(8'd0, 8'h77);
    sw();
    chk("full_drop_lost", lost, 1);
    tick();
    chk("full_lost_one_cycle", lost, 0);
    done();
    wr(8'd0, 8'h88);
    sw();
    chk("full_accept_lost", lost, 0);
    for (int k = 1; k < 7; k++) begin
      rd(8'd0, b);
      chk("full_order", b, 8'h50 + 8'(k));
      done();
    end
    rd(8'd0, b);
    chk("full_overwrite", b, 8'h88);
    chk("full_last_unread", unread, 1);
    done();
    chk("full_empty", unread, 0);

    // Order and wrap over many frames
    for (int n = 0; n < 20; n++) begin
      wr(8'd0, 8'hA0 + 8'(n));
      sw();
      rd(8'd0, b);
      chk("wrap_first_byte", b, 8'hA0 + 8'(n));
      done();
    end
    chk("wrap_unread", unread, 0);

    // Simultaneous switch and rd_done, with a write in the switch cycle
    wr(8'd0, 8'hC0); sw();
    wr(8'd0, 8'hC1); sw();
    wr(8'd0, 8'hC2); sw();
    step(1'b1, 8'd0, 8'hC3, 1'b1, 1'b1);
    chk("simul3_lost", lost, 0);
    rd(8'd0, b); chk("simul3_p0", b, 8'hC1); done();
    rd(8'd0, b); chk("simul3_p1", b, 8'hC2); done();
    rd(8'd0, b); chk("simul3_p2", b, 8'hC3);
    chk("simul3_unread", unread, 1);
    done();
    chk("simul3_empty", unread, 0);

    for (int k = 0; k < 7; k++) begin
      wr(8'd0, 8'hD0 + 8'(k));
      sw();
    end
    step(1'b1, 8'd0, 8'hEE, 1'b1, 1'b1);
    chk("simul7_lost", lost, 1);
    for (int k = 1; k < 7; k++) begin
      rd(8'd0, b);
      chk("simul7_order", b, 8'hD0 + 8'(k));
      done();
    end
    chk("simul7_empty", unread, 0);

    // rd_done with nothing committed is ignored
    done();
    chk("idle_done_unread", unread, 0);
    wr(8'd0, 8'h5A);
    sw();
    chk("idle_commit_unread", unread, 1);
    rd(8'd0, b); chk("idle_rd", b, 8'h5A);
    done();
    chk("idle_empty", unread, 0);

    // Reset in the middle of a frame
    wr(8'd0, 8'h61);
    sw();
    for (int k = 0; k < 5; k++) begin
      wr(8'(k), 8'h62 + 8'(k));
    end
    reset_n = 1'b0;
    #1;
    chk("midrst_unread", unread, 0);
    chk("midrst_lost", lost, 0);
    tick();
    reset_n = 1'b1;
    tick();
    wr(8'd0, 8'h99);
    sw();
    chk("midrst_commit", unread, 1);
    rd(8'd0, b); chk("midrst_rd", b, 8'h99);
    done();
    chk("midrst_empty", unread, 0);

`ifdef CD_RX_RAM_LEN_EN
    // Frame length tracking
    do_reset();
    chk("len_reset", rd_len, 0);
    for (int k = 0; k < 10; k++) begin
      wr(8'(k), 8'(k));
    end
    sw();
    chk("len_ten", rd_len, 10);
    wr(8'd255, 8'h01);
    sw();
    done();
    chk("len_256", rd_len, 256);
    done();
    for (int k = 0; k < 7; k++) begin
      wr(8'd3, 8'h02);
      sw();
    end
    chk("len_four", rd_len, 4);
    wr(8'd100, 8'h03);
    sw();
    chk("len_drop_lost", lost, 1);
    chk("len_drop_keep", rd_len, 4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
